// File: rtl/mor1kx_pic_multimode.sv
// Programmable interrupt controller with per-line run-time edge/level trigger
// selection (PICTR), optional input synchronisers and a registered lowest-ID encoder.
module mor1kx_pic_multimode #(
    parameter int          OPTION_PIC_NUM_IRQS    = 32,
    parameter string       OPTION_PIC_TRIGGER     = "EDGE",
    parameter logic [31:0] OPTION_PIC_NMI_MASK    = 32'h3,
    parameter int          OPTION_PIC_SYNC_STAGES = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [OPTION_PIC_NUM_IRQS-1:0] irq_i,
    input  logic                           spr_we_i,
    input  logic [15:0]                    spr_addr_i,
    input  logic [31:0]                    spr_dat_i,
    output logic                           spr_bus_ack,
    output logic [31:0]                    spr_dat_o,
    output logic [31:0]                    spr_picmr_o,
    output logic [31:0]                    spr_picsr_o,
    output logic                           irq_pending_o,
    output logic [4:0]                     irq_id_o
);

    localparam int          N          = OPTION_PIC_NUM_IRQS;
    localparam int          S          = OPTION_PIC_SYNC_STAGES;
    localparam logic [32:0] VALID_W    = (33'h1 << N) - 33'h1;
    localparam logic [31:0] VALID      = VALID_W[31:0];
    localparam logic [31:0] NMI        = OPTION_PIC_NMI_MASK & VALID;
    localparam logic [31:0] PICTR_RST  = (OPTION_PIC_TRIGGER == "EDGE") ? VALID : 32'h0;

    localparam logic [15:0] ADDR_PICMR = 16'h4800;
    localparam logic [15:0] ADDR_PICSR = 16'h4802;
    localparam logic [15:0] ADDR_PICTR = 16'h4803;

    if (OPTION_PIC_TRIGGER != "EDGE" && OPTION_PIC_TRIGGER != "LATCHED_LEVEL") begin : g_bad_trigger
        $fatal(1, "mor1kx_pic_multimode: unsupported OPTION_PIC_TRIGGER");
    end

    logic [N-1:0] s;
    logic [31:0]  s_w;
    logic [31:0]  prev;
    logic [31:0]  picmr;
    logic [31:0]  picsr;
    logic [31:0]  pictr;
    logic [31:0]  unmasked;
    logic [31:0]  event_v;
    logic [31:0]  picsr_next;
    logic [4:0]   low_id;
    logic         sel_mr;
    logic         sel_sr;
    logic         sel_tr;

    if (S == 0) begin : g_nosync
        assign s = irq_i;
    end else begin : g_sync
        logic [N-1:0] sync_q [S];
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k < S; k++) sync_q[k] <= '0;
            end else begin
                sync_q[0] <= irq_i;
                for (int k = 1; k < S; k++) sync_q[k] <= sync_q[k-1];
            end
        end
        assign s = sync_q[S-1];
    end

    always_comb begin
        s_w        = '0;
        s_w[N-1:0] = s;
    end

    assign sel_mr = spr_we_i && (spr_addr_i == ADDR_PICMR);
    assign sel_sr = spr_we_i && (spr_addr_i == ADDR_PICSR);
    assign sel_tr = spr_we_i && (spr_addr_i == ADDR_PICTR);

    // Edge lines fire only on a 0->1 of the unmasked level; prev tracks the raw
    // synchronised input so unmasking an already-high line is not an edge.
    assign unmasked = s_w & picmr;
    assign event_v  = ((pictr & unmasked & ~prev) | (~pictr & unmasked)) & VALID;

    // Write-1-to-clear first, then same-cycle events are ORed back in.
    assign picsr_next = ((sel_sr ? (picsr & ~spr_dat_i) : picsr) | event_v) & VALID;

    always_comb begin
        low_id = '0;
        for (int i = 31; i >= 0; i--) begin
            if (picsr[i]) low_id = 5'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev          <= '0;
            picmr         <= NMI;
            picsr         <= '0;
            pictr         <= PICTR_RST;
            irq_pending_o <= 1'b0;
            irq_id_o      <= '0;
        end else begin
            prev  <= s_w;
            picsr <= picsr_next;
            if (sel_mr) picmr <= (spr_dat_i & VALID) | NMI;
            if (sel_tr) pictr <= spr_dat_i & VALID;
            irq_pending_o <= |picsr;
            if (|picsr) irq_id_o <= low_id;
        end
    end

    always_comb begin
        case (spr_addr_i)
            ADDR_PICMR: spr_dat_o = picmr;
            ADDR_PICSR: spr_dat_o = picsr;
            ADDR_PICTR: spr_dat_o = pictr;
            default:    spr_dat_o = 32'h0;
        endcase
    end

    assign spr_bus_ack = 1'b1;
    assign spr_picmr_o = picmr;
    assign spr_picsr_o = picsr;

endmodule
